// File: rtl/btn_conditioner.sv
// Button input stage: two-flop synchroniser, per-channel debounce, then a
// priority arbiter that emits one registered press pulse per physical press.
//
//  state     | meaning
//  ----------+----------------------------------------------------------
//  ST_IDLE   | no press owned; the highest-priority new press wins a pulse
//  ST_LOCKED | a pulse was issued; ignore everything until all buttons are up
module btn_conditioner #(
    parameter int N_BTN           = 5,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_pulse,
    output logic             any_held
);

    typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

    localparam logic [CNT_W-1:0] LP_TC  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LP_ONE = CNT_W'(1);

    logic [N_BTN-1:0] r_s1;
    logic [N_BTN-1:0] r_s2;
    logic [N_BTN-1:0] r_level;
    logic [N_BTN-1:0] r_prev;
    logic [CNT_W-1:0] r_cnt [N_BTN];
    logic [N_BTN-1:0] r_pulse;
    state_t           r_state;

    logic [N_BTN-1:0] w_cand;
    logic [N_BTN-1:0] w_win;
    logic [N_BTN-1:0] w_pulse_nxt;
    state_t           w_state_nxt;

    // Any disagreement with the accepted level must persist for the full
    // window; a single agreeing sample restarts the count.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_s1    <= '0;
            r_s2    <= '0;
            r_level <= '0;
            r_prev  <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_s1   <= btn_raw;
            r_s2   <= r_s1;
            r_prev <= r_level;
            for (int i = 0; i < N_BTN; i++) begin
                if (r_s2[i] == r_level[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == LP_TC) begin
                    r_level[i] <= r_s2[i];
                    r_cnt[i]   <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + LP_ONE;
                end
            end
        end
    end

    assign w_cand = r_level & ~r_prev;

    // Fixed priority: bottom, center, top, left, right. Losers are dropped.
    always_comb begin
        w_win = '0;
        if (w_cand[2])      w_win[2] = 1'b1;
        else if (w_cand[0]) w_win[0] = 1'b1;
        else if (w_cand[1]) w_win[1] = 1'b1;
        else if (w_cand[3]) w_win[3] = 1'b1;
        else if (w_cand[4]) w_win[4] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_pulse <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pulse <= w_pulse_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (|w_cand) w_state_nxt = ST_LOCKED;
            ST_LOCKED: if (r_level == '0) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_pulse_nxt = '0;
        if (r_state == ST_IDLE) begin
            w_pulse_nxt = w_win;
        end
    end

    assign btn_level = r_level;
    assign btn_pulse = r_pulse;
    assign any_held  = |r_level;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with a 4-cycle debounce window;
// expected levels and pulse edges are hand-computed per scenario.
module tb_btn_conditioner;

    localparam int N_BTN = 5;
    localparam int DB    = 4;
    localparam int CW    = 8;

    logic             clk;
    logic             reset_n;
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_pulse;
    logic             any_held;

    int n_checks;
    int n_errors;

    btn_conditioner #(
        .N_BTN          (N_BTN),
        .DEBOUNCE_CYCLES(DB),
        .CNT_W          (CW)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .btn_raw  (btn_raw),
        .btn_level(btn_level),
        .btn_pulse(btn_pulse),
        .any_held (any_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Apply raw, then check for n edges. Level switches from lvl_from to
    // lvl_to at edge lvl_edge; pulse equals pls only after edge pls_edge.
    task automatic seq(input string tag, input logic [4:0] raw, input int n,
                       input logic [4:0] lvl_from, input logic [4:0] lvl_to,
                       input int lvl_edge, input logic [4:0] pls, input int pls_edge);
        logic [4:0] exp_l;
        logic [4:0] exp_p;
        btn_raw = raw;
        for (int i = 1; i <= n; i++) begin
            @(posedge clk);
            #1;
            exp_l = (i >= lvl_edge) ? lvl_to : lvl_from;
            exp_p = (i == pls_edge) ? pls : 5'b0;
            chk($sformatf("%s_lvl@%0d", tag, i), 32'(btn_level), 32'(exp_l));
            chk($sformatf("%s_pls@%0d", tag, i), 32'(btn_pulse), 32'(exp_p));
            chk($sformatf("%s_held@%0d", tag, i), 32'(any_held), 32'(|exp_l));
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_lvl"}, 32'(btn_level), 32'd0);
        chk({tag, "_pls"}, 32'(btn_pulse), 32'd0);
        chk({tag, "_held"}, 32'(any_held), 32'd0);
    endtask

    initial begin
        logic [4:0] bounce;
        logic [4:0] exp_l;
        logic [4:0] exp_p;
        n_checks = 0;
        n_errors = 0;
        reset_n  = 1'b0;
        btn_raw  = '0;

        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk_zero("reset");
        end
        reset_n = 1'b1;
        seq("idle", 5'b00000, 5, 5'b0, 5'b0, 99, 5'b0, 0);

        // 1: clean center press held 20 cycles
        seq("t1", 5'b00001, 20, 5'b0, 5'b00001, 6, 5'b00001, 7);
        seq("t1_rel", 5'b00000, 10, 5'b00001, 5'b0, 6, 5'b0, 0);

        // 2: 3-cycle glitch on top
        seq("t2_on", 5'b00010, 3, 5'b0, 5'b0, 99, 5'b0, 0);
        seq("t2_off", 5'b00000, 8, 5'b0, 5'b0, 99, 5'b0, 0);
        chk("t2_cnt", 32'(dut.r_cnt[1]), 32'd0);

        // 3: top+bottom together, bottom wins, top never fires
        seq("t3", 5'b00110, 12, 5'b0, 5'b00110, 6, 5'b00100, 7);
        seq("t3_botrel", 5'b00010, 10, 5'b00110, 5'b00010, 6, 5'b0, 0);
        seq("t3_rel", 5'b00000, 10, 5'b00010, 5'b0, 6, 5'b0, 0);

        // 4: left, then right while left held, then right alone
        seq("t4_left", 5'b01000, 12, 5'b0, 5'b01000, 6, 5'b01000, 7);
        seq("t4_right", 5'b11000, 12, 5'b01000, 5'b11000, 6, 5'b0, 0);
        seq("t4_rel", 5'b00000, 10, 5'b11000, 5'b0, 6, 5'b0, 0);
        seq("t4_right2", 5'b10000, 12, 5'b0, 5'b10000, 6, 5'b10000, 7);
        seq("t4_rel2", 5'b00000, 10, 5'b10000, 5'b0, 6, 5'b0, 0);

        // 5: center held through a 2-cycle reset
        seq("t5_hold", 5'b00001, 12, 5'b0, 5'b00001, 6, 5'b00001, 7);
        reset_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk_zero($sformatf("t5_rst%0d", i));
        end
        reset_n = 1'b1;
        seq("t5_after", 5'b00001, 12, 5'b0, 5'b00001, 6, 5'b00001, 7);
        seq("t5_rel", 5'b00000, 10, 5'b00001, 5'b0, 6, 5'b0, 0);

        // 6: bouncy right press 1,0,1,0,1 then steady; stable s2 after edge 6
        bounce  = 5'b10101;
        btn_raw = {bounce[0], 4'b0};
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk);
            #1;
            exp_l = (i >= 10) ? 5'b10000 : 5'b0;
            exp_p = (i == 11) ? 5'b10000 : 5'b0;
            chk($sformatf("t6_lvl@%0d", i), 32'(btn_level), 32'(exp_l));
            chk($sformatf("t6_pls@%0d", i), 32'(btn_pulse), 32'(exp_p));
            btn_raw = (i < 5) ? {bounce[i], 4'b0} : 5'b10000;
        end
        seq("t6_rel", 5'b00000, 10, 5'b10000, 5'b0, 6, 5'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
Upstream input stage for the game controller FSM. It takes the five raw, asynchronous push-button signals (center, top, bottom, left, right) and synchronises and debounces each one. It then emits at most one single-cycle press pulse per clock, with a fixed priority between buttons. A lockout rule gives exactly one FSM action per physical press, even when several buttons are pressed together or a button is held.

Parameters:
N_BTN, 5, number of button channels; bit order 0=center, 1=top, 2=bottom, 3=left, 4=right
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles needed to accept a level change (10 ms at 100 MHz); legal range 1 to 2^CNT_W-1
CNT_W, 20, width of each per-channel debounce counter

Ports:
clk  input  1  system clock; all logic on posedge
reset_n  input  1  synchronous, active-low reset
btn_raw  input  N_BTN  raw asynchronous button levels, 1 = pressed
btn_level  output  N_BTN  debounced level per button
btn_pulse  output  N_BTN  one-hot or zero single-cycle press pulse, registered
any_held  output  1  OR of btn_level

Behaviour:
- Reset (reset_n=0 at a posedge):
  - sync stages, debounced levels, previous-level register, counters and btn_pulse all go to 0.
  - Arbiter state goes to IDLE.
  - Reset wins over every other event in that cycle.
- Synchroniser: two flip-flops per channel (s1, s2). s2 is the sampled value.
- Debounce, per channel i, each posedge:
  - If s2[i] == btn_level[i], then cnt[i] <= 0.
  - Otherwise, if cnt[i] == DEBOUNCE_CYCLES-1, then btn_level[i] <= s2[i] and cnt[i] <= 0.
  - Otherwise cnt[i] <= cnt[i]+1.
- Debounce latency and glitches:
  - A clean raw transition first sampled at edge 1 appears on btn_level at edge 2+DEBOUNCE_CYCLES.
  - A glitch shorter than DEBOUNCE_CYCLES sampled cycles leaves btn_level unchanged and clears the counter.
  - Release is debounced identically.
- Press candidates: cand = btn_level & ~lvl_prev, where lvl_prev is btn_level delayed one cycle.
- Priority, highest first: bottom(2), center(0), top(1), left(3), right(4).
  - Only the highest-priority candidate is eligible.
  - Lower candidates in the same cycle are discarded, not queued.
- Arbiter FSM:
  - IDLE: if any cand, btn_pulse <= one-hot of the winner on the next edge, and the state goes to LOCKED. Otherwise btn_pulse <= 0.
  - LOCKED: btn_pulse <= 0; all candidates are discarded. When btn_level == 0, go to IDLE on that edge.
- Pulse timing and width:
  - btn_pulse is high for exactly one cycle.
  - Latency from btn_level rising to btn_pulse is 1 cycle, so a clean press sampled at edge 1 gives btn_pulse high after edge 3+DEBOUNCE_CYCLES.
- Held button: a button held indefinitely gives exactly one pulse. A new pulse needs all buttons released (debounced) first.
- Second button while holding: a second button pressed while the first is still held gives no pulse.
- Release-and-press on one edge: release of all buttons and a new press on the same edge is not possible, because btn_level must pass through 0, which returns the FSM to IDLE first.
- Held through reset: a button held across reset deassertion is re-debounced from 0 and produces one pulse 3+DEBOUNCE_CYCLES edges after release of reset.
- Continuous outputs: btn_level and any_held update every cycle, independent of lockout.

Test Plan:
1. DEBOUNCE_CYCLES=4; btn_raw[0] rises and is held 20 cycles → btn_level[0]=1 after edge 6; btn_pulse=5'b00001 for exactly one cycle after edge 7; no further pulse.
2. btn_raw[1] high for 3 cycles then low (glitch) → btn_level and btn_pulse stay 0; debounce counter returns to 0.
3. btn_raw=5'b00110 rising on the same cycle → single pulse 5'b00100 (bottom wins); top pulse never appears, even after bottom releases while top is still held.
4. Press left, then press right while left is held → one pulse 5'b01000; release both and press right → pulse 5'b10000.
5. Hold center, assert reset_n=0 for 2 cycles mid-hold, then release reset → all outputs 0 during reset; pulse 5'b00001 exactly 7 edges after reset release.
6. Bouncy press: btn_raw[4] toggles 1,0,1,0,1 per cycle then stays 1 → exactly one pulse 5'b10000, emitted 5 edges after the first stable-high sample reaches s2.
